data_memory: RTL and testbench

Data-memory responder on the MA-stage port of the RV32IM pipeline. It accepts the load/store request the CPU drives on `address`, `write_data`, `mem_read` and `mem_write`, and holds `busywait` high for a fixed access latency. It then completes the access, returning sign- or zero-extended load data or committing byte-laned store data. The CPU stalls every pipeline register and the PC on `busywait`.

---
 rtl/data_memory_pkg.sv | 63 ++++++
 rtl/data_memory_if.sv | 22 ++
 rtl/data_memory_load_aligner.sv | 26 ++
 rtl/data_memory.sv | 110 +++++++++++
 tb/tb_data_memory.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM state type and request decode for the MA-stage data memory.
package data_memory_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RD_CTRL_W = 4;
    localparam int unsigned WR_CTRL_W = 3;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned LANES     = XLEN / 8;

    localparam int unsigned RD_EN_BIT = 3;
    localparam int unsigned WR_EN_BIT = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;
    localparam logic [1:0] F3_SW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       rd_en;
        logic       wr_en;
        logic [2:0] rd_f3;
        logic [1:0] wr_f3;
    } mem_req_t;

    function automatic mem_req_t decode_req(input logic [RD_CTRL_W-1:0] mem_read,
                                            input logic [WR_CTRL_W-1:0] mem_write);
        mem_req_t r;
        r.rd_en = mem_read[RD_EN_BIT];
        r.wr_en = mem_write[WR_EN_BIT];
        r.rd_f3 = mem_read[2:0];
        r.wr_f3 = mem_write[1:0];
        return r;
    endfunction

    // Byte-lane enables; misaligned halfwords fall back to address[1].
    function automatic logic [LANES-1:0] store_lanes(input logic [1:0] f3, input logic [1:0] lane);
        case (f3)
            F3_SB:   return 4'b0001 << lane;
            F3_SH:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [1:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            F3_SB:   return {4{d[7:0]}};
            F3_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// CPU-side MA-stage memory port: the CPU drives the master side, the memory the slave side.
interface data_memory_if;
    import data_memory_pkg::*;

    logic [XLEN-1:0]      address;
    logic [XLEN-1:0]      write_data;
    logic [RD_CTRL_W-1:0] mem_read;
    logic [WR_CTRL_W-1:0] mem_write;
    logic [XLEN-1:0]      read_data;
    logic                 busywait;

    modport master (
        output address, write_data, mem_read, mem_write,
        input  read_data, busywait
    );

    modport slave (
        input  address, write_data, mem_read, mem_write,
        output read_data, busywait
    );

endinterface

// File: rtl/data_memory_load_aligner.sv
// Picks the addressed byte/halfword out of a 32-bit word and sign- or zero-extends it.
module load_aligner
    import data_memory_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_lane,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'(i_word >> {i_lane, 3'b000});
        w_half = 16'(i_word >> {i_lane[1], 4'b0000});
        case (i_funct3)
            F3_LB:   o_data_c = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data_c = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data_c = {24'h000000, w_byte};
            F3_LHU:  o_data_c = {16'h0000, w_half};
            default: o_data_c = i_word;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency data memory responder: IDLE -> BUSY (LATENCY cycles) -> DONE, byte-laned stores.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 4
) (
    input logic          clk,
    input logic          rst,
    data_memory_if.slave bus
);

    localparam int unsigned     DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [XLEN-1:0]       r_mem [DEPTH];
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_read_data;

    mem_req_t              w_req;
    logic                  w_valid;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic [XLEN-1:0]       w_word;
    logic [XLEN-1:0]       w_load;
    logic [LANES-1:0]      w_lanes;
    logic [XLEN-1:0]       w_wdata;
    logic [XLEN-1:0]       w_merged;
    logic                  w_commit;
    logic                  w_unused_addr;

    assign w_req         = decode_req(bus.mem_read, bus.mem_write);
    assign w_valid       = w_req.rd_en | w_req.wr_en;
    assign w_idx         = bus.address[ADDR_WIDTH+1:2];
    assign w_lane        = bus.address[1:0];
    assign w_word        = r_mem[w_idx];
    assign w_unused_addr = ^bus.address[XLEN-1:ADDR_WIDTH+2];

    load_aligner u_load_aligner (
        .i_word   (w_word),
        .i_lane   (w_lane),
        .i_funct3 (w_req.rd_f3),
        .o_data_c (w_load)
    );

    // Read-modify-write merge of the addressed word for the store lanes.
    always_comb begin
        w_lanes  = store_lanes(w_req.wr_f3, w_lane);
        w_wdata  = store_data(w_req.wr_f3, bus.write_data);
        w_merged = w_word;
        for (int b = 0; b < int'(LANES); b++) begin
            if (w_lanes[b]) begin
                w_merged[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    // A store lands only on the final BUSY edge with the request still held.
    assign w_commit = (r_state == ST_BUSY) && w_req.wr_en && (r_cnt == '0);

    // Stall from the request cycle through the last BUSY cycle; DONE and aborts drop it.
    assign bus.busywait  = w_valid && (r_state != ST_DONE);
    assign bus.read_data = r_read_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (!w_valid) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= ST_DONE;
                        if (!w_req.wr_en) begin
                            r_read_data <= w_load;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Random and directed load/store traffic against a byte-array model of the data memory.
module tb_data_memory;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_if bus ();

    data_memory #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        exp_busy;
    logic [31:0] exp_rd;
    bit          chk_en   = 1'b0;
    int          busy_run = 0;
    int          last_run = 0;
    logic [7:0]  mmem [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [9:0]  a;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        a = addr[9:0];
        b = mmem[a];
        h = {mmem[{a[9:1], 1'b1}], mmem[{a[9:1], 1'b0}]};
        w = {mmem[{a[9:2], 2'd3}], mmem[{a[9:2], 2'd2}], mmem[{a[9:2], 2'd1}], mmem[{a[9:2], 2'd0}]};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [1:0] f3, input logic [31:0] addr, input logic [31:0] d);
        logic [9:0] a;
        a = addr[9:0];
        case (f3)
            2'b00: mmem[a] = d[7:0];
            2'b01: begin
                mmem[{a[9:1], 1'b0}] = d[7:0];
                mmem[{a[9:1], 1'b1}] = d[15:8];
            end
            default: for (int i = 0; i < 4; i++) mmem[{a[9:2], 2'(i)}] = d[8*i +: 8];
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.address    = '0;
        bus.write_data = '0;
        bus.mem_read   = '0;
        bus.mem_write  = '0;
    endtask

    // One access from the request cycle to the edge closing DONE (or abort / reset at cycle abort_k).
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int abort_k, input bit rst_abort,
                          output logic [31:0] got);
        bus.address    = addr;
        bus.write_data = wdata;
        bus.mem_read   = {rd, f3};
        bus.mem_write  = {wr, f3[1:0]};
        exp_busy       = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            cycle();
            if (k == abort_k) begin
                clear_req();
                exp_busy = 1'b0;
                if (rst_abort) begin
                    rst    = 1'b1;
                    exp_rd = '0;
                end
                cycle();
                rst = 1'b0;
                got = bus.read_data;
                return;
            end
        end
        cycle();
        exp_busy = 1'b0;
        if (wr) model_store(f3[1:0], addr, wdata);
        else if (rd) exp_rd = model_load(f3, addr);
        @(negedge clk);
        got = bus.read_data;
        cycle();
    endtask

    task automatic idle(input int n);
        clear_req();
        exp_busy = 1'b0;
        repeat (n) cycle();
    endtask

    // Per-cycle comparison against the model's expected port values.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busywait", 32'(bus.busywait), 32'(exp_busy));
            check("read_data", bus.read_data, exp_rd);
            if (bus.busywait) busy_run++;
            else if (busy_run != 0) begin
                last_run = busy_run;
                busy_run = 0;
            end
        end
    end

    initial begin
        logic [31:0] got;
        logic [31:0] pre;
        bit          rd, wr;
        int          ak;
        rst = 1'b1;
        clear_req();
        exp_busy = 1'b0;
        exp_rd   = '0;
        cycle();
        chk_en = 1'b1;
        cycle();
        check("reset_read_data", bus.read_data, 32'h0);
        check("reset_busywait", 32'(bus.busywait), 32'h0);
        rst = 1'b0;
        cycle();

        for (int w = 0; w < 256; w++) access(1'b0, 1'b1, 3'b010, 32'(w) << 2, $urandom, 0, 1'b0, got);

        access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0, got);
        check("busy_len_sw", 32'(last_run), 32'd5);
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, got);
        check("lw_10", got, 32'hDEADBEEF);
        check("busy_len_lw", 32'(last_run), 32'd5);
        check("model_lw_10", model_load(3'b010, 32'h10), 32'hDEADBEEF);

        pre = model_load(3'b010, 32'h100);
        access(1'b0, 1'b1, 3'b000, 32'h103, 32'h12345680, 0, 1'b0, got);
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b0, got);
        check("lb_103", got, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b0, got);
        check("lbu_103", got, 32'h00000080);
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, got);
        check("lw_100_lanes", got, {8'h80, pre[23:0]});

        access(1'b0, 1'b1, 3'b001, 32'h22, 32'hABCD8001, 0, 1'b0, got);
        access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 0, 1'b0, got);
        check("lh_22", got, 32'hFFFF8001);
        access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 0, 1'b0, got);
        check("lhu_22", got, 32'h00008001);
        access(1'b1, 1'b0, 3'b001, 32'h23, 32'h0, 0, 1'b0, got);
        check("lh_23_aligned", got, 32'hFFFF8001);
        check("model_lhu_22", model_load(3'b101, 32'h22), 32'h00008001);

        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, got);
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, got);
        check("b2b_second_lw", got, 32'hDEADBEEF);
        check("b2b_busy_len", 32'(last_run), 32'd5);

        pre = model_load(3'b010, 32'h40);
        access(1'b0, 1'b1, 3'b010, 32'h40, 32'h55AA55AA, 2, 1'b1, got);
        check("rst_read_data", got, 32'h0);
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 1'b0, got);
        check("rst_no_commit", got, pre);

        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, got);
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, LAT - 2, 1'b0, got);
        check("abort_keep", got, 32'hDEADBEEF);

        access(1'b0, 1'b1, 3'b010, 32'hFFFF_F414, 32'hCAFEF00D, 0, 1'b0, got);
        access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 0, 1'b0, got);
        check("addr_wrap", got, 32'hCAFEF00D);

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0:       begin rd = 1'b1; wr = 1'b1; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            ak = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LAT)) : 0;
            access(rd, wr, 3'($urandom), $urandom, $urandom, ak, 1'b0, got);
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
